display_scheduler: RTL

- Time-shares the two-digit seven-segment display between two independent value sources (requesters A and B).
- Each winner's 8-bit value is latched and held on the display for a fixed dwell time, then the display is re-arbitrated round-robin.
- Sits between value producers (counters, status registers) and the `seven_segment_decoder` `addr` input. A `blank` flag lets the top level gate segments off while the display is idle.

---
 rtl/display_scheduler.sv | 106 ++++++++++
 1 files changed

// File: rtl/display_scheduler.sv
// Round-robin time-sharing of the seven-segment display between two value sources.
// Each winner's value is latched into addr and held for HOLD_CYCLES before re-arbitration.
module display_scheduler #(
    parameter int AW          = 8,
    parameter int HOLD_CYCLES = 12000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_a,
    input  logic [AW-1:0] data_a,
    input  logic          req_b,
    input  logic [AW-1:0] data_b,
    output logic          grant_a,
    output logic          grant_b,
    output logic          done,
    output logic          owner,
    output logic [AW-1:0] addr,
    output logic          blank
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          owner_q, owner_d;
    logic          grant_a_q, grant_a_d;
    logic          grant_b_q, grant_b_d;
    logic          done_q, done_d;
    logic          blank_q, blank_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            owner_q   <= 1'b1;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            done_q    <= 1'b0;
            blank_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            owner_q   <= owner_d;
            grant_a_q <= grant_a_d;
            grant_b_q <= grant_b_d;
            done_q    <= done_d;
            blank_q   <= blank_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        owner_d   = owner_q;
        grant_a_d = 1'b0;
        grant_b_d = 1'b0;
        done_d    = 1'b0;
        blank_d   = blank_q;
        unique case (state_q)
            IDLE: begin
                blank_d = 1'b1;
                // On a tie the source that did not own the display last wins.
                if (req_a && (!req_b || owner_q)) begin
                    addr_d    = data_a;
                    owner_d   = 1'b0;
                    grant_a_d = 1'b1;
                    blank_d   = 1'b0;
                    cnt_d     = '0;
                    state_d   = SHOW;
                end else if (req_b) begin
                    addr_d    = data_b;
                    owner_d   = 1'b1;
                    grant_b_d = 1'b1;
                    blank_d   = 1'b0;
                    cnt_d     = '0;
                    state_d   = SHOW;
                end
            end
            SHOW: begin
                if (cnt_q == LAST) begin
                    done_d  = 1'b1;
                    blank_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_a = grant_a_q;
    assign grant_b = grant_b_q;
    assign done    = done_q;
    assign owner   = owner_q;
    assign addr    = addr_q;
    assign blank   = blank_q;

endmodule
